noc_pe_interface: RTL
=====================

# noc_pe_interface

Network interface between a processing element (PE) and the PE port of one torus switch. Injection: accepts host words with a destination coordinate, builds packets `{data, y, x}`, queues them, and feeds them to the switch under its ready/valid handshake. Ejection: the switch PE output has no backpressure, so every delivered packet is captured into a queue. The header is stripped and the payload goes to the host under ready/valid. Ejection overflow and misrouted packets are flagged.

## Interface
- `x_coord`, 0: this node's X coordinate.
- `y_coord`, 0: this node's Y coordinate.
- `data_width`, 256: payload width.
- `x_size`, 1: X field width.
- `y_size`, 1: Y field width.
- `total_width`, x_size+y_size+data_width: packet width.
- `INJ_DEPTH`, 4: injection queue entries; power of two, ≥2.
- `EJ_DEPTH`, 4: ejection queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  the single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  host inject word valid.
- `s_ready`  out  1  injection queue not full.
- `s_data`  in  data_width  inject payload.
- `s_dest_x`  in  x_size  destination X.
- `s_dest_y`  in  y_size  destination Y.
- `o_valid`  out  1  packet to switch valid (to switch `i_valid_pe`).
- `o_data`  out  total_width  packet to switch (to switch `i_data_pe`).
- `i_ready`  in  1  switch accepts (from switch `o_ready_pe`).
- `i_valid`  in  1  packet from switch (from switch `o_valid_pe`).
- `i_data`  in  total_width  packet from switch.
- `m_valid`  out  1  ejected payload valid.
- `m_ready`  in  1  host accepts payload.
- `m_data`  out  data_width  ejected payload.
- `o_ej_overflow`  out  1  sticky: at least one packet dropped.
- `o_drop_cnt`  out  8  saturating count of dropped packets.
- `o_misroute`  out  1  sticky: a packet arrived with a header not equal to (x_coord, y_coord).

## Operation
- Packet layout:
  - bits [x_size-1:0] = X.
  - bits [x_size+y_size-1:x_size] = Y.
  - upper data_width bits = payload.
- Injection queue (first-word fall-through):
  - `s_ready` = count < INJ_DEPTH.
  - Push on `s_valid & s_ready`.
  - `o_valid` = count ≠ 0; `o_data` = head.
  - Pop on `o_valid & i_ready`.
  - `o_data` stays stable while `o_valid & ~i_ready`.
  - No bypass: an empty queue never presents in the same cycle it is pushed.
  - When full, push is blocked even if a pop occurs that cycle.
  - Push and pop in the same cycle leave count unchanged.
- Ejection queue:
  - Accept when `i_valid & (count < EJ_DEPTH | pop)`, where pop = `m_valid & m_ready`.
  - If `i_valid` arrives while full and not popping, the packet is dropped: `o_ej_overflow` ← 1 and `o_drop_cnt` increments, saturating at 255.
  - `m_valid` = count ≠ 0; `m_data` = head payload bits.
- Misroute check: if `i_valid` and the header X/Y ≠ (x_coord, y_coord), `o_misroute` ← 1. The packet is still enqueued normally.
- Pointers wrap modulo depth. Counts are $clog2(DEPTH)+1 bits wide.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous assert): all pointers and counts 0.
  - `o_valid`=0, `m_valid`=0, `o_ej_overflow`=0, `o_misroute`=0, `o_drop_cnt`=0.
  - `s_ready`=0 while `rstn` low; `s_ready`=1 from the first cycle after release.
  - Queued contents are discarded. Reset mid-operation loses in-flight packets without any flag.
- Injection latency: word accepted at edge N → `o_valid` high after edge N. Sustained 1 packet/cycle.
- Ejection latency: `i_valid` sampled at edge N → `m_valid` high after edge N. Sustained 1 packet/cycle.
- `s_ready` and `m_valid` are functions of registered state only. `o_valid` does not depend on `i_ready`, so no combinational loop forms with the switch.

## Structure
- Shared package `noc_pkg`: packet field offset constants and the header-extract/packet-build helper functions.
- One sub-module, `noc_sync_fifo` (WIDTH, DEPTH; push/pop/full/empty/count, head fall-through), instantiated twice.
- Drop, overflow and misroute logic live in the top level.

## Test plan
Bench parameters: data_width=8, x_size=y_size=1, node (0,0), depths 4.
1. Reset: hold `rstn`=0 mid-traffic → all outputs 0 immediately. After release `s_ready`=1, queues empty, flags 0.
2. Inject with `i_ready`=1:
   - Send 0xA1→(1,0), 0xA2→(0,1), 0xA3→(1,1) on consecutive cycles.
   - `o_data` = 10'h285, 10'h28A, 10'h28F, one per cycle, starting one cycle after the first push.
3. Injection backpressure: `i_ready`=0, offer 5 words.
   - `s_ready` falls after the 4th word; `o_data` holds the head.
   - Raise `i_ready` → all 5 words drain in order with no loss or duplication.
4. Ejection overflow: `m_ready`=0, `i_valid` on 5 consecutive cycles with header (0,0).
   - 4 packets stored; 5th dropped; `o_ej_overflow`=1, `o_drop_cnt`=1.
   - Then `m_ready`=1 → 4 payloads delivered in order.
5. Full with simultaneous pop: ejection queue full, `m_ready`=1 and `i_valid`=1 in the same cycle → packet accepted, `o_drop_cnt` unchanged, count stays 4.
6. Misroute: `i_valid` with header X=1,Y=0 and payload 0x55 → `o_misroute`=1 next cycle, and `m_data`=0x55 is still delivered.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the torus NoC PE interface: packet field offsets
// and small header/packet helpers used by the interface logic.
package noc_pkg;

  localparam int DROP_CNT_W   = 8;
  localparam int DROP_CNT_MAX = (1 << DROP_CNT_W) - 1;

  // Packet layout from LSB upward: X, then Y, then the payload.
  function automatic int x_lsb();
    return 0;
  endfunction

  function automatic int y_lsb(input int x_size);
    return x_size;
  endfunction

  function automatic int data_lsb(input int x_size, input int y_size);
    return x_size + y_size;
  endfunction

  function automatic logic hdr_match(input logic [31:0] hx, input logic [31:0] hy,
                                     input logic [31:0] cx, input logic [31:0] cy);
    return (hx == cx) && (hy == cy);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Small synchronous FIFO with head fall-through; the caller guarantees it
// never pushes into a full queue without a simultaneous pop, nor pops empty.
module noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/noc_pe_interface.sv
// PE-side network interface of one torus switch: packetises and queues host
// words for injection, and captures/strips ejected packets for the host.
module noc_pe_interface
  import noc_pkg::*;
#(
  parameter int x_coord     = 0,
  parameter int y_coord     = 0,
  parameter int data_width  = 256,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int INJ_DEPTH   = 4,
  parameter int EJ_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [data_width-1:0]  s_data,
  input  logic [x_size-1:0]      s_dest_x,
  input  logic [y_size-1:0]      s_dest_y,
  output logic                   o_valid,
  output logic [total_width-1:0] o_data,
  input  logic                   i_ready,
  input  logic                   i_valid,
  input  logic [total_width-1:0] i_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [data_width-1:0]  m_data,
  output logic                   o_ej_overflow,
  output logic [7:0]             o_drop_cnt,
  output logic                   o_misroute
);

  localparam int X_LSB = x_lsb();
  localparam int Y_LSB = y_lsb(x_size);
  localparam int D_LSB = data_lsb(x_size, y_size);

  logic                    ready_reg;
  logic                    inj_push, inj_pop, inj_full, inj_empty;
  logic [$clog2(INJ_DEPTH):0] inj_count;
  logic                    ej_push, ej_pop, ej_full, ej_empty;
  logic [$clog2(EJ_DEPTH):0]  ej_count;
  logic                    drop;
  logic                    hdr_ok;
  logic [x_size-1:0]       hdr_x;
  logic [y_size-1:0]       hdr_y;
  logic [DROP_CNT_W-1:0]   drop_cnt_reg;
  logic                    overflow_reg;
  logic                    misroute_reg;
  logic                    unused_ok;

  // Holds s_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ready_reg <= 1'b0;
    else       ready_reg <= 1'b1;
  end

  assign s_ready  = ready_reg & ~inj_full;
  assign inj_push = s_valid & s_ready;
  assign o_valid  = ~inj_empty;
  assign inj_pop  = o_valid & i_ready;

  noc_sync_fifo #(.WIDTH(total_width), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inj_push),
    .pop   (inj_pop),
    .din   ({s_data, s_dest_y, s_dest_x}),
    .dout  (o_data),
    .full  (inj_full),
    .empty (inj_empty),
    .count (inj_count)
  );

  // The switch cannot be stalled, so a full queue only accepts if it is
  // draining a payload in the same cycle.
  assign m_valid = ~ej_empty;
  assign ej_pop  = m_valid & m_ready;
  assign ej_push = i_valid & (~ej_full | ej_pop);
  assign drop    = i_valid & ej_full & ~ej_pop;

  noc_sync_fifo #(.WIDTH(data_width), .DEPTH(EJ_DEPTH)) u_ej_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (ej_push),
    .pop   (ej_pop),
    .din   (i_data[D_LSB +: data_width]),
    .dout  (m_data),
    .full  (ej_full),
    .empty (ej_empty),
    .count (ej_count)
  );

  assign hdr_x  = i_data[X_LSB +: x_size];
  assign hdr_y  = i_data[Y_LSB +: y_size];
  assign hdr_ok = hdr_match(32'(hdr_x), 32'(hdr_y), 32'(x_coord), 32'(y_coord));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_reg <= '0;
      overflow_reg <= 1'b0;
      misroute_reg <= 1'b0;
    end else begin
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != DROP_CNT_W'(DROP_CNT_MAX)) drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
      if (i_valid && !hdr_ok) misroute_reg <= 1'b1;
    end
  end

  assign o_ej_overflow = overflow_reg;
  assign o_drop_cnt    = drop_cnt_reg;
  assign o_misroute    = misroute_reg;

  assign unused_ok = &{1'b0, inj_count, ej_count};

endmodule
